// File: rtl/dds_sample_formatter_if.sv
// Stream bundle between the DDS/NCO lookup and the sample formatter, and onward to the mixer/DAC path.
// Carries: in_mode/in_dat/in_vld/in_rdy (upstream beat), out_dat/out_vld/out_rdy (downstream beat), clip_cnt.
// Modports: master = traffic source/sink side (drives inputs, consumes outputs); slave = formatter side.
interface dds_sample_formatter_if #(
    parameter int W  = 8,
    parameter int CH = 2
) ();
    logic [1:0]      in_mode;   // transform select, travels with its beat
    logic [CH*W-1:0] in_dat;    // channel c at [c*W +: W]
    logic            in_vld;
    logic            in_rdy;
    logic [CH*W-1:0] out_dat;   // same packing as in_dat
    logic            out_vld;
    logic            out_rdy;
    logic [15:0]     clip_cnt;  // saturation event count

    modport master (
        output in_mode, in_dat, in_vld, out_rdy,
        input  in_rdy, out_dat, out_vld, clip_cnt
    );

    modport slave (
        input  in_mode, in_dat, in_vld, out_rdy,
        output in_rdy, out_dat, out_vld, clip_cnt
    );
endinterface

// File: rtl/dds_sample_formatter.sv
// Purpose: per-beat DDS sample format transform (bypass / offset rotate / MSB flip / saturating negate).
// Latency: 2 cycles (stage A registers the beat, stage B registers the result); one beat per cycle.
// Backpressure: in_rdy = !A_vld || !B_vld || out_rdy; out_dat held while out_vld && !out_rdy.
//
// Ports:
//   i_clk    - clock
//   i_rst    - asynchronous reset, active-high; discards in-flight beats
//   io_strm  - dds_sample_formatter_if.slave (in_mode/in_dat/in_vld/in_rdy,
//              out_dat/out_vld/out_rdy, clip_cnt)
// Optional feature: define DDS_FMT_CLIP_CNT_EN to enable the clip event counter;
// otherwise clip_cnt is tied to 0 (negate still saturates).
module dds_sample_formatter #(
    parameter int W      = 8,                 // sample width per channel, >= 2
    parameter int CH     = 2,                 // channels per beat
    parameter int OFFSET = 2**(W-1) - 1       // mode 1 rotate constant, < 2**W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    dds_sample_formatter_if.slave  io_strm
);

    localparam logic [W-1:0] OFFSET_W = W'(OFFSET);
    localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] ONE_W    = W'(1);

    // Stage A content: the mode is captured with the data so a later mode
    // change on the input cannot affect a beat already accepted.
    typedef struct packed {
        logic [1:0]      mode;
        logic [CH*W-1:0] dat;
    } beat_t;

    // Single-channel transform.
    function automatic logic [W-1:0] fmt_sample(input logic [W-1:0] x, input logic [1:0] m);
        logic [W-1:0] y;
        case (m)
            2'd0:    y = x;
            // Legacy rotate; wraps modulo 2**W, carry/borrow dropped.
            2'd1:    y = (x < OFFSET_W) ? (x + OFFSET_W) : (x - OFFSET_W);
            // Offset-binary <-> two's complement.
            2'd2:    y = {~x[W-1], x[W-2:0]};
            // Negate; the most negative value has no positive twin, so clamp.
            default: y = (x == MIN_NEG) ? MAX_POS : ((~x) + ONE_W);
        endcase
        return y;
    endfunction

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    logic            r_a_vld;
    beat_t           r_a;
    logic            r_b_vld;
    logic [CH*W-1:0] r_b_dat;

    logic            w_b_free;   // stage B can take a beat this cycle
    logic            w_a_adv;    // stage A content moves into stage B
    logic            w_in_rdy;
    logic            w_acc;      // upstream beat accepted into stage A
    logic [CH*W-1:0] w_res;

    // in_rdy depends only on register state and out_rdy, never on in_vld.
    assign w_b_free = !r_b_vld || io_strm.out_rdy;
    assign w_a_adv  = r_a_vld && w_b_free;
    assign w_in_rdy = !r_a_vld || w_b_free;
    assign w_acc    = io_strm.in_vld && w_in_rdy;

    assign io_strm.in_rdy  = w_in_rdy;
    assign io_strm.out_vld = r_b_vld;
    assign io_strm.out_dat = r_b_dat;

    // ---------------------------------------------------------------
    // Stage A: capture beat + mode
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a_vld <= 1'b0;
            r_a     <= '0;
        end else if (w_acc) begin
            r_a_vld  <= 1'b1;
            r_a.mode <= io_strm.in_mode;
            r_a.dat  <= io_strm.in_dat;
        end else if (w_a_adv) begin
            r_a_vld <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Transform of the stage A beat, all channels independent
    // ---------------------------------------------------------------
    always_comb begin
        w_res = '0;
        for (int c = 0; c < CH; c++) begin
            w_res[c*W +: W] = fmt_sample(r_a.dat[c*W +: W], r_a.mode);
        end
    end

    // ---------------------------------------------------------------
    // Stage B: registered result; only reloads when empty or draining,
    // so out_dat is frozen while the downstream stalls.
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_b_vld <= 1'b0;
            r_b_dat <= '0;
        end else if (w_a_adv) begin
            r_b_vld <= 1'b1;
            r_b_dat <= w_res;
        end else if (io_strm.out_rdy) begin
            r_b_vld <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Clip event counter
    // ---------------------------------------------------------------
`ifdef DDS_FMT_CLIP_CNT_EN
    logic [15:0] r_clip_cnt;
    logic [15:0] w_nclip;    // clipping channels in the stage A beat
    logic [16:0] w_sum;      // extra bit detects counter overflow

    always_comb begin
        w_nclip = '0;
        for (int c = 0; c < CH; c++) begin
            if (r_a.mode == 2'd3 && r_a.dat[c*W +: W] == MIN_NEG) begin
                w_nclip = w_nclip + 16'd1;
            end
        end
    end

    assign w_sum = {1'b0, r_clip_cnt} + {1'b0, w_nclip};

    // Counted as the beat moves A -> B, so a stalled beat is counted once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clip_cnt <= '0;
        end else if (w_a_adv) begin
            r_clip_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
        end
    end

    assign io_strm.clip_cnt = r_clip_cnt;
`else
    assign io_strm.clip_cnt = '0;
`endif

endmodule
